// File: rtl/serial_add_ctrl_if.sv
// Handshake and data bundle for the bit-serial adder controller.
// The master side issues start plus operands; the slave side returns
// status flags and the registered result.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
) ();

   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             cin_in;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a_in, b_in, cin_in,
      input  ready, busy, done, sum, cout
   );

   modport slave (
      input  start, a_in, b_in, cin_in,
      output ready, busy, done, sum, cout
   );

endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice per clock, LSB first.
// IDLE accepts a start and captures the operands, RUN walks WIDTH bits,
// DONE flags the freshly written result for a single cycle.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   serial_add_ctrl_if.slave   bus
);

   localparam int             CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Full-adder sum bit.
   function automatic logic fa_sum(input logic a, input logic b, input logic c);
      return a ^ b ^ c;
   endfunction

   // Full-adder carry (majority of the three inputs).
   function automatic logic fa_carry(input logic a, input logic b, input logic c);
      return (a & b) | (b & c) | (c & a);
   endfunction

   state_t           state_r;
   state_t           state_next_s;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] acc_next_s;
   logic             carry_r;
   logic [CW-1:0]    count_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             fa_sum_s;
   logic             fa_carry_s;
   logic             last_bit_s;
   logic             ready_s;
   logic             busy_s;
   logic             done_s;

   assign fa_sum_s   = fa_sum(a_sh_r[0], b_sh_r[0], carry_r);
   assign fa_carry_s = fa_carry(a_sh_r[0], b_sh_r[0], carry_r);
   assign last_bit_s = (count_r == LAST_CNT);

   // Accumulator shifts right with the new sum bit entering at the MSB; written
   // bit-wise so that WIDTH=1 needs no special case.
   always_comb begin
      acc_next_s            = acc_r >> 1'b1;
      acc_next_s[WIDTH-1]   = fa_sum_s;
   end

   // State register; reset wins over every transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic: start only matters in IDLE, DONE always falls back.
   always_comb begin
      state_next_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_bit_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Status flags decoded purely from the current state.
   always_comb begin
      ready_s = 1'b0;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      case (state_r)
         ST_IDLE: ready_s = 1'b1;
         ST_RUN:  busy_s  = 1'b1;
         ST_DONE: done_s  = 1'b1;
         default: ready_s = 1'b0;
      endcase
   end

   // Datapath: capture on accept, one slice per RUN edge, result on the last slice.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_r  <= {WIDTH{1'b0}};
         b_sh_r  <= {WIDTH{1'b0}};
         acc_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         count_r <= {CW{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         cout_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  a_sh_r  <= bus.a_in;
                  b_sh_r  <= bus.b_in;
                  carry_r <= bus.cin_in;
                  acc_r   <= {WIDTH{1'b0}};
                  count_r <= {CW{1'b0}};
               end
            end
            ST_RUN: begin
               a_sh_r  <= a_sh_r >> 1'b1;
               b_sh_r  <= b_sh_r >> 1'b1;
               acc_r   <= acc_next_s;
               carry_r <= fa_carry_s;
               count_r <= count_r + CNT_ONE;
               if (last_bit_s) begin
                  sum_r  <= acc_next_s;
                  cout_r <= fa_carry_s;
               end
            end
            default: begin
               count_r <= count_r;
            end
         endcase
      end
   end

   assign bus.ready = ready_s;
   assign bus.busy  = busy_s;
   assign bus.done  = done_s;
   assign bus.sum   = sum_r;
   assign bus.cout  = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a WIDTH=8 and a WIDTH=1 instance
// share clock and reset; expected results come from plain integer addition.
module tb_serial_add_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model state: last completed result of each instance.
   logic [7:0] exp_sum8;
   logic       exp_cout8;
   logic       exp_sum1;
   logic       exp_cout1;

   serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
   serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

   serial_add_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
   serial_add_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   always #5 clk = ~clk;

   function automatic logic [8:0] ref_add8(input logic [7:0] a, input logic [7:0] b, input logic c);
      int unsigned t;
      t = int'(a) + int'(b) + int'(c);
      return t[8:0];
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus8.start = 1'b1; bus8.a_in = 8'hAA; bus8.b_in = 8'h55; bus8.cin_in = 1'b1;
      bus1.start = 1'b1; bus1.a_in = 1'b1;  bus1.b_in = 1'b1;  bus1.cin_in = 1'b1;
      repeat (3) @(negedge clk);
      // start held high during reset must not leave IDLE
      vectors++;
      if ({bus8.ready, bus8.busy, bus8.done} !== 3'b100) begin
         miscompares++;
         $display("FAIL reset_prio8 flags got %b want 100", {bus8.ready, bus8.busy, bus8.done});
      end
      bus8.start = 1'b0; bus1.start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus8.ready, bus8.busy, bus8.done, bus8.cout, bus8.sum} !== {3'b100, 9'd0}) begin
         miscompares++;
         $display("FAIL reset8 got r%b b%b d%b c%b s%h want r1 b0 d0 c0 s00",
                  bus8.ready, bus8.busy, bus8.done, bus8.cout, bus8.sum);
      end
      vectors++;
      if ({bus1.ready, bus1.busy, bus1.done, bus1.cout, bus1.sum} !== 5'b10000) begin
         miscompares++;
         $display("FAIL reset1 got r%b b%b d%b c%b s%b want 1 0 0 0 0",
                  bus1.ready, bus1.busy, bus1.done, bus1.cout, bus1.sum);
      end
      exp_sum8 = 8'd0; exp_cout8 = 1'b0; exp_sum1 = 1'b0; exp_cout1 = 1'b0;
   endtask

   // One addition on the WIDTH=8 instance with full cycle-by-cycle checks.
   // Operands are scrambled right after the accept edge; keep_start leaves
   // start high through RUN and DONE to show it is ignored there.
   task automatic test_single_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                  input logic keep_start, input string tag);
      logic [8:0] res;
      logic [8:0] old;
      res = ref_add8(a, b, cin);
      old = {exp_cout8, exp_sum8};
      vectors++;
      if (bus8.ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s pre_ready got %b want 1", tag, bus8.ready);
      end
      bus8.start = 1'b1; bus8.a_in = a; bus8.b_in = b; bus8.cin_in = cin;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         bus8.start  = keep_start;
         bus8.a_in   = 8'($urandom);
         bus8.b_in   = 8'($urandom);
         bus8.cin_in = 1'($urandom);
         vectors++;
         if ({bus8.ready, bus8.busy, bus8.done} !== 3'b010) begin
            miscompares++;
            $display("FAIL %s run_flags cyc%0d got %b want 010", tag, k, {bus8.ready, bus8.busy, bus8.done});
         end
         vectors++;
         if ({bus8.cout, bus8.sum} !== old) begin
            miscompares++;
            $display("FAIL %s run_hold cyc%0d got %h want %h", tag, k, {bus8.cout, bus8.sum}, old);
         end
         @(negedge clk);
      end
      vectors++;
      if ({bus8.ready, bus8.busy, bus8.done} !== 3'b001) begin
         miscompares++;
         $display("FAIL %s done_flags got %b want 001", tag, {bus8.ready, bus8.busy, bus8.done});
      end
      vectors++;
      if ({bus8.cout, bus8.sum} !== res) begin
         miscompares++;
         $display("FAIL %s result a=%h b=%h c=%b got %h want %h", tag, a, b, cin, {bus8.cout, bus8.sum}, res);
      end
      @(negedge clk);
      bus8.start = 1'b0;
      vectors++;
      if ({bus8.ready, bus8.busy, bus8.done, bus8.cout, bus8.sum} !== {3'b100, res}) begin
         miscompares++;
         $display("FAIL %s post_idle got r%b b%b d%b %h want r1 b0 d0 %h",
                  tag, bus8.ready, bus8.busy, bus8.done, {bus8.cout, bus8.sum}, res);
      end
      exp_sum8 = res[7:0]; exp_cout8 = res[8];
   endtask

   task automatic test_directed();
      test_single_op8(8'd200, 8'd100, 1'b0, 1'b0, "dir_200_100");
      vectors++;
      if ({bus8.cout, bus8.sum} !== {1'b1, 8'd44}) begin
         miscompares++;
         $display("FAIL dir_44 got %h want 12c", {bus8.cout, bus8.sum});
      end
      test_single_op8(8'hFF, 8'h00, 1'b1, 1'b0, "dir_ff_00_1");
      test_single_op8(8'h0F, 8'h01, 1'b0, 1'b0, "dir_0f_01_0");
      test_single_op8(8'hFF, 8'hFF, 1'b1, 1'b0, "dir_ff_ff_1");
   endtask

   task automatic test_width1();
      for (int code = 0; code < 8; code++) begin
         logic [2:0] abc;
         logic [1:0] res;
         abc = 3'(code);
         res = 2'(int'(abc[2]) + int'(abc[1]) + int'(abc[0]));
         bus1.start = 1'b1; bus1.a_in = abc[2]; bus1.b_in = abc[1]; bus1.cin_in = abc[0];
         @(negedge clk);
         bus1.start = 1'b0; bus1.a_in = ~abc[2]; bus1.b_in = ~abc[1]; bus1.cin_in = ~abc[0];
         vectors++;
         if ({bus1.ready, bus1.busy, bus1.done, bus1.cout, bus1.sum} !== {3'b010, exp_cout1, exp_sum1}) begin
            miscompares++;
            $display("FAIL w1_run code%0d got %b want %b", code,
                     {bus1.ready, bus1.busy, bus1.done, bus1.cout, bus1.sum}, {3'b010, exp_cout1, exp_sum1});
         end
         @(negedge clk);
         vectors++;
         if ({bus1.ready, bus1.busy, bus1.done, bus1.cout, bus1.sum} !== {3'b001, res}) begin
            miscompares++;
            $display("FAIL w1_done code%0d got %b want %b", code,
                     {bus1.ready, bus1.busy, bus1.done, bus1.cout, bus1.sum}, {3'b001, res});
         end
         @(negedge clk);
         vectors++;
         if ({bus1.ready, bus1.done} !== 2'b10) begin
            miscompares++;
            $display("FAIL w1_idle code%0d got %b want 10", code, {bus1.ready, bus1.done});
         end
         exp_cout1 = res[1]; exp_sum1 = res[0];
      end
   endtask

   // start held high: accepts land every 10 edges, each done 8 edges later.
   task automatic test_back_to_back();
      logic [8:0] res_q[$];
      logic [8:0] last;
      logic [8:0] r;
      logic       exp_done;
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      last = {exp_cout8, exp_sum8};
      bus8.start = 1'b1;
      for (int j = 0; j < 40; j++) begin
         a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
         bus8.a_in = a; bus8.b_in = b; bus8.cin_in = c;
         if ((j % 10) == 0) res_q.push_back(ref_add8(a, b, c));
         @(negedge clk);
         exp_done = (j >= 8) && (((j - 8) % 10) == 0);
         vectors++;
         if (bus8.done !== exp_done) begin
            miscompares++;
            $display("FAIL b2b_done edge%0d got %b want %b", j, bus8.done, exp_done);
         end
         if (exp_done && res_q.size() > 0) begin
            r = res_q.pop_front();
            last = r;
            vectors++;
            if ({bus8.cout, bus8.sum} !== r) begin
               miscompares++;
               $display("FAIL b2b_result edge%0d got %h want %h", j, {bus8.cout, bus8.sum}, r);
            end
         end
      end
      bus8.start = 1'b0;
      vectors++;
      if (bus8.ready !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_ready got %b want 1", bus8.ready);
      end
      exp_sum8 = last[7:0]; exp_cout8 = last[8];
   endtask

   task automatic test_reset_mid_run();
      bus8.start = 1'b1; bus8.a_in = 8'hA5; bus8.b_in = 8'h3C; bus8.cin_in = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if ({bus8.ready, bus8.busy, bus8.done, bus8.cout, bus8.sum} !== {3'b100, 9'd0}) begin
         miscompares++;
         $display("FAIL midrun_reset got r%b b%b d%b %h want r1 b0 d0 000",
                  bus8.ready, bus8.busy, bus8.done, {bus8.cout, bus8.sum});
      end
      exp_sum8 = 8'd0; exp_cout8 = 1'b0; exp_sum1 = 1'b0; exp_cout1 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         vectors++;
         if ({bus8.done, bus8.cout, bus8.sum} !== 10'd0) begin
            miscompares++;
            $display("FAIL midrun_nodone cyc%0d got d%b %h want d0 000", k, bus8.done, {bus8.cout, bus8.sum});
         end
      end
      test_single_op8(8'h5A, 8'hC3, 1'b0, 1'b0, "after_reset");
   endtask

   task automatic test_start_ignored();
      for (int i = 0; i < 4; i++) begin
         test_single_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, "start_ignored");
      end
   endtask

   task automatic test_random();
      logic [7:0] a;
      logic [7:0] b;
      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 3))
            0:       a = 8'hFF;
            1:       a = 8'h00;
            default: a = 8'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0:       b = 8'hFF;
            1:       b = 8'h00;
            default: b = 8'($urandom);
         endcase
         test_single_op8(a, b, 1'($urandom), 1'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      rst = 1'b1;
      bus8.start = 1'b0; bus8.a_in = 8'd0; bus8.b_in = 8'd0; bus8.cin_in = 1'b0;
      bus1.start = 1'b0; bus1.a_in = 1'b0; bus1.b_in = 1'b0; bus1.cin_in = 1'b0;
      exp_sum8 = 8'd0; exp_cout8 = 1'b0; exp_sum1 = 1'b0; exp_cout1 = 1'b0;
      test_reset();
      test_directed();
      test_width1();
      test_back_to_back();
      test_reset_mid_run();
      test_start_ignored();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
